// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter: shares one synchronous 1R1W word RAM between two
// picorv32-style native memory masters with round-robin and boot lock.
//
// Ports:
//   clk_i, reset_ni      clock (rising edge), async active-low reset
//   boot_i               1: only master 1 (boot loader) may be granted
//   m0_* / m1_*          native memory ports: valid/addr/wdata/wstrb in,
//                        ready pulse and rdata out
//   ram_addr_o           RAM word address (byte addr bits [AW+1:2])
//   ram_wen_o            RAM byte write enables
//   ram_wdata_o          RAM write data
//   ram_rd_data_i        RAM read data, one cycle after the address
//   oob_o                one-cycle pulse when an out-of-range access ends
module ram_bus_arbiter #(
    parameter  int unsigned RamWords = 256,
    localparam int unsigned AW       = $clog2(RamWords)
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic          boot_i,

    input  logic          m0_valid_i,
    input  logic [31:0]   m0_addr_i,
    input  logic [31:0]   m0_wdata_i,
    input  logic [3:0]    m0_wstrb_i,
    output logic          m0_ready_o,
    output logic [31:0]   m0_rdata_o,

    input  logic          m1_valid_i,
    input  logic [31:0]   m1_addr_i,
    input  logic [31:0]   m1_wdata_i,
    input  logic [3:0]    m1_wstrb_i,
    output logic          m1_ready_o,
    output logic [31:0]   m1_rdata_o,

    output logic [AW-1:0] ram_addr_o,
    output logic [3:0]    ram_wen_o,
    output logic [31:0]   ram_wdata_o,
    input  logic [31:0]   ram_rd_data_i,

    output logic          oob_o
);

    // Byte window size, widened so 4*RamWords cannot overflow 32 bits.
    localparam logic [33:0] Limit = 34'(RamWords) << 2;

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    state_t state;
    logic   gnt_q;
    logic   last_q;
    logic   inrange_q;
    logic   ready0_q;
    logic   ready1_q;
    logic   oob_q;

    logic [1:0]  elig;
    logic        req;
    logic        gnt_c;
    logic        sel;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_wstrb;
    logic        sel_inrange;

    // Grant decision. On a tie the master that did not win last time
    // gets the RAM; last_q resets to 1 so master 0 wins the first tie.
    always_comb begin
        elig  = {m1_valid_i, m0_valid_i & ~boot_i};
        gnt_c = 1'b0;
        unique case (elig)
            2'b00:   gnt_c = 1'b0;
            2'b01:   gnt_c = 1'b0;
            2'b10:   gnt_c = 1'b1;
            2'b11:   gnt_c = ~last_q;
            default: gnt_c = 1'b0;
        endcase
    end

    // A grant is only live in IDLE and never while reset is asserted,
    // so no write can reach the RAM once reset goes low.
    assign req = (state == IDLE) & (|elig) & reset_ni;

    // In RESP the registered grant keeps the RAM buses on the same master.
    assign sel = (state == IDLE) ? gnt_c : gnt_q;

    always_comb begin
        sel_addr  = m0_addr_i;
        sel_wdata = m0_wdata_i;
        sel_wstrb = m0_wstrb_i;
        if (sel) begin
            sel_addr  = m1_addr_i;
            sel_wdata = m1_wdata_i;
            sel_wstrb = m1_wstrb_i;
        end
    end

    assign sel_inrange = ({2'b00, sel_addr} < Limit);

    assign ram_addr_o  = sel_addr[AW+1:2];
    assign ram_wdata_o = sel_wdata;
    assign ram_wen_o   = (req && sel_inrange) ? sel_wstrb : 4'b0000;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state     <= IDLE;
            gnt_q     <= 1'b0;
            last_q    <= 1'b1;
            inrange_q <= 1'b0;
            ready0_q  <= 1'b0;
            ready1_q  <= 1'b0;
            oob_q     <= 1'b0;
        end else begin
            ready0_q <= 1'b0;
            ready1_q <= 1'b0;
            oob_q    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|elig) begin
                        state     <= RESP;
                        gnt_q     <= gnt_c;
                        last_q    <= gnt_c;
                        inrange_q <= sel_inrange;
                        ready0_q  <= ~gnt_c;
                        ready1_q  <= gnt_c;
                        oob_q     <= ~sel_inrange;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The RAM answers during RESP; out-of-range accesses return zero.
    assign m0_ready_o = ready0_q;
    assign m1_ready_o = ready1_q;
    assign m0_rdata_o = (ready0_q && inrange_q) ? ram_rd_data_i : 32'h0;
    assign m1_rdata_o = (ready1_q && inrange_q) ? ram_rd_data_i : 32'h0;
    assign oob_o      = oob_q;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// tb_ram_bus_arbiter: directed bench for ram_bus_arbiter with a
// behavioural synchronous RAM attached.
module tb_ram_bus_arbiter;

    localparam int unsigned RamWords = 256;

    logic        clk;
    logic        rst_n;
    logic        boot;
    logic        m0_valid;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [3:0]  m0_wstrb;
    logic        m0_ready;
    logic [31:0] m0_rdata;
    logic        m1_valid;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_wstrb;
    logic        m1_ready;
    logic [31:0] m1_rdata;
    logic [7:0]  ram_addr;
    logic [3:0]  ram_wen;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rd;
    logic        oob;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [RamWords];

    ram_bus_arbiter #(.RamWords(RamWords)) dut (
        .clk_i        (clk),
        .reset_ni     (rst_n),
        .boot_i       (boot),
        .m0_valid_i   (m0_valid),
        .m0_addr_i    (m0_addr),
        .m0_wdata_i   (m0_wdata),
        .m0_wstrb_i   (m0_wstrb),
        .m0_ready_o   (m0_ready),
        .m0_rdata_o   (m0_rdata),
        .m1_valid_i   (m1_valid),
        .m1_addr_i    (m1_addr),
        .m1_wdata_i   (m1_wdata),
        .m1_wstrb_i   (m1_wstrb),
        .m1_ready_o   (m1_ready),
        .m1_rdata_o   (m1_rdata),
        .ram_addr_o   (ram_addr),
        .ram_wen_o    (ram_wen),
        .ram_wdata_o  (ram_wdata),
        .ram_rd_data_i(ram_rd),
        .oob_o        (oob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM, read-before-write, word 0 preloaded during reset.
    always @(posedge clk) begin
        if (!rst_n) begin
            mem[0] <= 32'hA5A5A5A5;
        end else begin
            ram_rd <= mem[ram_addr];
            for (int b = 0; b < 4; b++) begin
                if (ram_wen[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One uncontended access from master m, started in IDLE.
    task automatic single(input string tag, input bit m,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, input logic [3:0] exp_wen,
                          input logic [31:0] exp_rd, input bit chk_rd,
                          input bit exp_oob);
        logic [31:0] idx;
        idx = {24'b0, a[9:2]};
        if (m) begin
            m1_valid = 1'b1; m1_addr = a; m1_wdata = wd; m1_wstrb = ws;
        end else begin
            m0_valid = 1'b1; m0_addr = a; m0_wdata = wd; m0_wstrb = ws;
        end
        #1;
        check({tag, "_wen"}, {28'b0, ram_wen}, {28'b0, exp_wen});
        check({tag, "_addr"}, {24'b0, ram_addr}, idx);
        tick();
        check({tag, "_rdy"}, {30'b0, m1_ready, m0_ready},
              m ? 32'd2 : 32'd1);
        check({tag, "_oob"}, {31'b0, oob}, {31'b0, exp_oob});
        if (chk_rd) check({tag, "_rd"}, m ? m1_rdata : m0_rdata, exp_rd);
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        tick();
    endtask

    initial begin
        rst_n    = 1'b0;
        boot     = 1'b0;
        m0_valid = 1'b1; m0_addr = 32'h30; m0_wdata = 32'h12345678;
        m0_wstrb = 4'hF;
        m1_valid = 1'b1; m1_addr = 32'h30; m1_wdata = 32'h0;
        m1_wstrb = 4'h0;

        // Reset held with both masters requesting.
        repeat (3) tick();
        check("rst_rdy", {30'b0, m1_ready, m0_ready}, 32'd0);
        check("rst_wen", {28'b0, ram_wen}, 32'd0);
        check("rst_oob", {31'b0, oob}, 32'd0);
        check("rst_rd0", m0_rdata, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_wen", {28'b0, ram_wen}, 32'hF);
        check("rel_addr", {24'b0, ram_addr}, 32'h0C);
        tick();
        check("rel_rdy", {30'b0, m1_ready, m0_ready}, 32'd1);
        m0_valid = 1'b0;
        tick();
        tick();
        check("rel_rdy1", {30'b0, m1_ready, m0_ready}, 32'd2);
        check("rel_rd1", m1_rdata, 32'h12345678);
        m1_valid = 1'b0;
        tick();

        // Single write then read.
        single("t2w", 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 4'hF, 32'h0, 1'b0, 1'b0);
        single("t2r", 1'b0, 32'h10, 32'h0, 4'h0, 4'h0, 32'hDEADBEEF, 1'b1, 1'b0);
        single("t3p", 1'b1, 32'h20, 32'h11112222, 4'hF, 4'hF, 32'h0, 1'b0, 1'b0);

        // Contention: strict alternation starting with master 0.
        m0_valid = 1'b1; m0_addr = 32'h10; m0_wstrb = 4'h0;
        m1_valid = 1'b1; m1_addr = 32'h20; m1_wstrb = 4'h0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("t3_r0_%0d", k), {31'b0, m0_ready},
                  (k % 4 == 1) ? 32'd1 : 32'd0);
            check($sformatf("t3_r1_%0d", k), {31'b0, m1_ready},
                  (k % 4 == 3) ? 32'd1 : 32'd0);
            check($sformatf("t3_d0_%0d", k), m0_rdata,
                  (k % 4 == 1) ? 32'hDEADBEEF : 32'h0);
            check($sformatf("t3_d1_%0d", k), m1_rdata,
                  (k % 4 == 3) ? 32'h11112222 : 32'h0);
        end
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        tick();

        // Boot lock: master 0 stalls until boot drops.
        boot     = 1'b1;
        m0_valid = 1'b1;
        m1_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("t4_r0_%0d", k), {31'b0, m0_ready}, 32'd0);
            check($sformatf("t4_r1_%0d", k), {31'b0, m1_ready},
                  (k % 2 == 1) ? 32'd1 : 32'd0);
        end
        boot = 1'b0;
        #1;
        check("t4_addr", {24'b0, ram_addr}, 32'd4);
        tick();
        check("t4_rdy", {30'b0, m1_ready, m0_ready}, 32'd1);
        check("t4_rd", m0_rdata, 32'hDEADBEEF);
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        tick();

        // Out-of-range write from the loader.
        single("t5w", 1'b1, 32'h400, 32'hBADBAD00, 4'hF, 4'h0, 32'h0, 1'b1, 1'b1);
        check("t5_oob_end", {31'b0, oob}, 32'd0);
        single("t5r", 1'b0, 32'h0, 32'h0, 4'h0, 4'h0, 32'hA5A5A5A5, 1'b1, 1'b0);

        // Byte strobe on byte 1 only.
        single("t6w", 1'b0, 32'h0, 32'h00003C00, 4'b0010, 4'b0010, 32'h0, 1'b0, 1'b0);
        single("t6r", 1'b0, 32'h0, 32'h0, 4'h0, 4'h0, 32'hA5A53CA5, 1'b1, 1'b0);

        // Reset during RESP drops ready at once.
        m0_valid = 1'b1; m0_addr = 32'h10; m0_wstrb = 4'h0;
        tick();
        check("t6_rdy", {31'b0, m0_ready}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_rdy", {31'b0, m0_ready}, 32'd0);
        check("t6_rst_rd", m0_rdata, 32'd0);
        tick();
        check("t6_rst_wen", {28'b0, ram_wen}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("t6_re_addr", {24'b0, ram_addr}, 32'd4);
        tick();
        check("t6_re_rdy", {31'b0, m0_ready}, 32'd1);
        check("t6_re_rd", m0_rdata, 32'hDEADBEEF);
        m0_valid = 1'b0;
        tick();
        check("t6_idle", {30'b0, m1_ready, m0_ready}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
